// File: rtl/pe_group_addr_sequencer.sv
// Write/read address sequencer for one convolution tile of the PE-group entry buffer.
// Optional macro SEQ_STALL_CNT_EN adds a saturating StallCount output.
module pe_group_addr_sequencer #(
   parameter int AddressCount         = 27,
   parameter int AddressCountWidth    = 5,
   parameter int WindowSize           = 9,
   parameter int WindowSizeWidth      = 4,
   parameter int EntryReadTimes       = 5,
   parameter int EntryReadTimesWidth  = 3,
   parameter int TotalWriteTimes      = 27,
   parameter int TotalWriteTimesWidth = 9,
   parameter int TotalReadTimes       = 135,
   parameter int TotalReadTimesWidth  = 9
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            WEn,
   input  logic                            REn,
   output logic [AddressCountWidth-1:0]    WAddr,
   output logic [AddressCountWidth-1:0]    RAddr,
   output logic                            WrAllow,
   output logic                            RdAllow,
   output logic [EntryReadTimesWidth-1:0]  Pass,
   output logic [TotalWriteTimesWidth-1:0] WCount,
   output logic [TotalReadTimesWidth-1:0]  RCount,
`ifdef SEQ_STALL_CNT_EN
   output logic [TotalReadTimesWidth+3:0]  StallCount,
`endif
   output logic                            busy,
   output logic                            done
);

   localparam logic [AddressCountWidth-1:0]    AC_LAST   = AddressCountWidth'(AddressCount - 1);
   localparam logic [AddressCountWidth-1:0]    WS_STEP   = AddressCountWidth'(WindowSize);
   localparam logic [AddressCountWidth-1:0]    BASE_LAST = AddressCountWidth'(AddressCount - WindowSize);
   localparam logic [WindowSizeWidth-1:0]      WS_LAST   = WindowSizeWidth'(WindowSize - 1);
   localparam logic [EntryReadTimesWidth-1:0]  ERT_LAST  = EntryReadTimesWidth'(EntryReadTimes - 1);
   localparam logic [TotalWriteTimesWidth-1:0] TW_MAX    = TotalWriteTimesWidth'(TotalWriteTimes);
   localparam logic [TotalReadTimesWidth-1:0]  TR_MAX    = TotalReadTimesWidth'(TotalReadTimes);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                          state, state_nxt;
   logic [AddressCountWidth-1:0]    base, base_nxt, waddr_nxt, raddr_nxt;
   logic [WindowSizeWidth-1:0]      offset, offset_nxt;
   logic [EntryReadTimesWidth-1:0]  pass_nxt;
   logic [TotalWriteTimesWidth-1:0] wcount_nxt;
   logic [TotalReadTimesWidth-1:0]  rcount_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The DONE transition looks at post-handshake counts so the final handshake edge enters DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (wcount_nxt == TW_MAX && rcount_nxt == TR_MAX) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == RUN);
      done    = (state == DONE);
      WrAllow = (state == RUN) && (WCount < TW_MAX);
      RdAllow = (state == RUN) && (RCount < TR_MAX);
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      waddr_nxt  = WAddr;
      wcount_nxt = WCount;
      rcount_nxt = RCount;
      pass_nxt   = Pass;
      base_nxt   = base;
      offset_nxt = offset;
      if (state == IDLE) begin
         if (start) begin
            waddr_nxt  = '0;
            wcount_nxt = '0;
            rcount_nxt = '0;
            pass_nxt   = '0;
            base_nxt   = '0;
            offset_nxt = '0;
         end
      end else if (state == RUN) begin
         if (WEn && WrAllow) begin
            waddr_nxt  = (WAddr == AC_LAST) ? '0 : WAddr + 1'b1;
            wcount_nxt = WCount + 1'b1;
         end
         if (REn && RdAllow) begin
            rcount_nxt = RCount + 1'b1;
            if (offset != WS_LAST) begin
               offset_nxt = offset + 1'b1;
            end else begin
               offset_nxt = '0;
               if (Pass != ERT_LAST) begin
                  pass_nxt = Pass + 1'b1;
               end else begin
                  pass_nxt = '0;
                  base_nxt = (base == BASE_LAST) ? '0 : base + WS_STEP;
               end
            end
         end
      end
      raddr_nxt = base_nxt + AddressCountWidth'(offset_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         WAddr  <= '0;
         RAddr  <= '0;
         WCount <= '0;
         RCount <= '0;
         Pass   <= '0;
         base   <= '0;
         offset <= '0;
      end else begin
         WAddr  <= waddr_nxt;
         RAddr  <= raddr_nxt;
         WCount <= wcount_nxt;
         RCount <= rcount_nxt;
         Pass   <= pass_nxt;
         base   <= base_nxt;
         offset <= offset_nxt;
      end
   end

`ifdef SEQ_STALL_CNT_EN
   // Counts RUN cycles where the consumer could read but did not; saturates at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         StallCount <= '0;
      else if (state == IDLE && start)
         StallCount <= '0;
      else if (RdAllow && !REn && StallCount != '1)
         StallCount <= StallCount + 1'b1;
   end
`endif

endmodule

// File: tb/tb_pe_group_addr_sequencer.sv
// Self-checking bench: default-size instance plus a wrap-configured instance (AddressCount=18).
module tb_pe_group_addr_sequencer;

   localparam int ERT = 5;
   localparam int WS  = 9;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start, wen, ren;
   logic [4:0] waddr, raddr;
   logic       wrallow, rdallow, busy, done;
   logic [2:0] pass;
   logic [8:0] wcount, rcount;

   logic       w_start, w_wen, w_ren;
   logic [4:0] w_waddr, w_raddr;
   logic       w_wrallow, w_rdallow, w_busy, w_done;
   logic [2:0] w_pass;
   logic [8:0] w_wcount, w_rcount;
`ifdef SEQ_STALL_CNT_EN
   logic [12:0] stall, w_stall;
`endif

   pe_group_addr_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .WEn(wen), .REn(ren),
      .WAddr(waddr), .RAddr(raddr), .WrAllow(wrallow), .RdAllow(rdallow),
      .Pass(pass), .WCount(wcount), .RCount(rcount),
`ifdef SEQ_STALL_CNT_EN
      .StallCount(stall),
`endif
      .busy(busy), .done(done)
   );

   pe_group_addr_sequencer #(
      .AddressCount(18), .AddressCountWidth(5), .WindowSize(9), .WindowSizeWidth(4),
      .EntryReadTimes(5), .EntryReadTimesWidth(3), .TotalWriteTimes(36),
      .TotalWriteTimesWidth(9), .TotalReadTimes(180), .TotalReadTimesWidth(9)
   ) dut_w (
      .clk(clk), .rst(rst), .start(w_start), .WEn(w_wen), .REn(w_ren),
      .WAddr(w_waddr), .RAddr(w_raddr), .WrAllow(w_wrallow), .RdAllow(w_rdallow),
      .Pass(w_pass), .WCount(w_wcount), .RCount(w_rcount),
`ifdef SEQ_STALL_CNT_EN
      .StallCount(w_stall),
`endif
      .busy(w_busy), .done(w_done)
   );

   int checks = 0;
   int errors = 0;
   int exp_w[$];
   int exp_r[$];
   int exp_p[$];

   logic [4:0] s_waddr, s_raddr;
   logic       s_wrallow, s_rdallow, s_busy, s_done;
   logic [2:0] s_pass;
   logic [8:0] s_wcount, s_rcount;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input bit wrap);
      s_waddr   = wrap ? w_waddr   : waddr;
      s_raddr   = wrap ? w_raddr   : raddr;
      s_wrallow = wrap ? w_wrallow : wrallow;
      s_rdallow = wrap ? w_rdallow : rdallow;
      s_busy    = wrap ? w_busy    : busy;
      s_done    = wrap ? w_done    : done;
      s_pass    = wrap ? w_pass    : pass;
      s_wcount  = wrap ? w_wcount  : wcount;
      s_rcount  = wrap ? w_rcount  : rcount;
   endtask

   task automatic drive(input bit wrap, input logic st, input logic we, input logic re);
      if (wrap) begin w_start = st; w_wen = we; w_ren = re; end
      else      begin start   = st; wen   = we; ren   = re; end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      sample(1'b0);
      check({tag, "_waddr"},  s_waddr,   0);
      check({tag, "_raddr"},  s_raddr,   0);
      check({tag, "_pass"},   s_pass,    0);
      check({tag, "_wcount"}, s_wcount,  0);
      check({tag, "_rcount"}, s_rcount,  0);
      check({tag, "_wrallow"},s_wrallow, 0);
      check({tag, "_rdallow"},s_rdallow, 0);
      check({tag, "_busy"},   s_busy,    0);
      check({tag, "_done"},   s_done,    0);
   endtask

   // Runs one whole tile; expected write/read address streams are built up front from the tile shape.
   task automatic run_tile(input bit wrap, input int ac, input int tw, input int period,
                           input bit spurious, input int stalls, input int stall_exp);
      int tr, base, cyc, last_read, left;
      logic we, re, st;
      tr = tw * ERT;
      exp_w.delete(); exp_r.delete(); exp_p.delete();
      for (int i = 0; i < tw; i++) exp_w.push_back(i % ac);
      base = 0;
      for (int win = 0; win < tw / WS; win++) begin
         for (int p = 0; p < ERT; p++)
            for (int o = 0; o < WS; o++) begin
               exp_r.push_back(base + o);
               exp_p.push_back(p);
            end
         base = (base + WS == ac) ? 0 : base + WS;
      end

      drive(wrap, 1'b1, 1'b0, 1'b0);
      tick();
      drive(wrap, 1'b0, 1'b0, 1'b0);
      sample(wrap);
      check("start_busy", s_busy, 1);
      check("start_wcount", s_wcount, 0);
      check("start_rcount", s_rcount, 0);
`ifdef SEQ_STALL_CNT_EN
      if (!wrap) check("stall_cleared", stall, 0);
`endif

      last_read = -10;
      left = stalls;
      for (cyc = 0; cyc < 3000; cyc++) begin
         sample(wrap);
         if (s_done) break;
         we = spurious ? 1'b1 : s_wrallow;
         re = s_rdallow && (cyc % period == 0);
         if (s_rdallow && left > 0) begin
            re = 1'b0;
            left--;
         end
         st = spurious && (cyc == 20);
         if (exp_r.size() > 0) begin
            check("raddr", s_raddr, exp_r[0]);
            check("pass", s_pass, exp_p[0]);
         end
         if (re) begin
            if (exp_r.size() > 0) begin
               void'(exp_r.pop_front());
               void'(exp_p.pop_front());
            end else begin
               check("extra_read_allowed", s_rdallow, 0);
            end
            last_read = cyc;
         end
         if (we && s_wrallow) begin
            if (exp_w.size() > 0) check("waddr", s_waddr, exp_w.pop_front());
            else check("extra_write_allowed", s_wrallow, 0);
         end
         drive(wrap, st, we, re);
         tick();
      end
      drive(wrap, 1'b0, 1'b0, 1'b0);

      check("done_seen", s_done, 1);
      check("done_latency", cyc, last_read + 1);
      check("end_wcount", s_wcount, tw);
      check("end_rcount", s_rcount, tr);
      check("end_waddr", s_waddr, tw % ac);
      check("end_busy", s_busy, 0);
      check("end_wrallow", s_wrallow, 0);
      check("end_rdallow", s_rdallow, 0);
      check("reads_left", exp_r.size(), 0);
      check("writes_left", exp_w.size(), 0);
`ifdef SEQ_STALL_CNT_EN
      if (!wrap && stall_exp >= 0) check("stall_count", stall, stall_exp);
`endif
      tick();
      sample(wrap);
      check("post_done", s_done, 0);
      check("post_busy", s_busy, 0);
      check("hold_wcount", s_wcount, tw);
      check("hold_rcount", s_rcount, tr);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();
      check_zero("idle");

      // Reset held for three cycles in the middle of a tile.
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (10) tick();
      sample(1'b0);
      check("midrun_busy", s_busy, 1);
      check("midrun_wcount", s_wcount, 10);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         sample(1'b0);
         check("rst_no_done", s_done, 0);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_zero("midrun_reset");
      tick();
      check_zero("after_reset");

      run_tile(1'b0, 27, 27, 1, 1'b0, 0, -1);   // full tile, no stalls
      run_tile(1'b0, 27, 27, 3, 1'b0, 0, -1);   // read backpressure
      run_tile(1'b0, 27, 27, 1, 1'b1, 0, -1);   // spurious start and WEn
      run_tile(1'b1, 18, 36, 1, 1'b0, 0, -1);   // write and window-base wrap
      run_tile(1'b0, 27, 27, 1, 1'b0, 10, 10);  // ten read stalls
`ifdef SEQ_STALL_CNT_EN
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("stall_restart", stall, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_group_addr_sequencer.md
Name: pe_group_addr_sequencer

Overview:
- Generates WAddr/RAddr for the PE-group entry buffer and its valid/read-count address controller over one convolution tile.
- Writes fill entries circularly. Reads sweep a window of WindowSize entries EntryReadTimes times, then advance to the next window, so every entry is read exactly EntryReadTimes times.
- Tile runs from a start pulse to a done pulse; addresses advance only on the controller's WEn/REn handshakes.

Parameters:
- AddressCount, 27, number of buffer entries; must be a multiple of WindowSize
- AddressCountWidth, 5, width of WAddr/RAddr
- WindowSize, 9, entries per read window
- WindowSizeWidth, 4, width of window offset counter
- EntryReadTimes, 5, read passes per window
- EntryReadTimesWidth, 3, width of pass counter
- TotalWriteTimes, 27, writes per tile
- TotalWriteTimesWidth, 9, width of write counter
- TotalReadTimes, 135, reads per tile; equals TotalWriteTimes*EntryReadTimes
- TotalReadTimesWidth, 9, width of read counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin tile; sampled only in IDLE
- WEn  in  1  write handshake fired this cycle (from address controller)
- REn  in  1  read handshake fired this cycle (from address controller)
- WAddr  out  AddressCountWidth  current write entry
- RAddr  out  AddressCountWidth  current read entry (window base + offset)
- WrAllow  out  1  producer may present write data
- RdAllow  out  1  consumer may request reads
- Pass  out  EntryReadTimesWidth  current read pass within window
- WCount  out  TotalWriteTimesWidth  writes completed this tile
- RCount  out  TotalReadTimesWidth  reads completed this tile
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at tile end

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset (synchronous, active-high): state IDLE. WAddr, RAddr, Pass, WCount, RCount = 0. WrAllow, RdAllow, busy, done = 0. Internal window base and offset = 0.
- rst dominates all other inputs, including mid-tile; the tile is abandoned with no done pulse.
- IDLE:
  - start=1 -> RUN next cycle; all counters and addresses cleared on that edge.
  - start=0 -> stay in IDLE.
- RUN:
  - busy=1.
  - WrAllow = (WCount < TotalWriteTimes).
  - RdAllow = (RCount < TotalReadTimes).
  - Both are combinational from registered state, valid the same cycle.
- Write path, on WEn && WrAllow:
  - WAddr <= (WAddr==AddressCount-1) ? 0 : WAddr+1.
  - WCount <= WCount+1.
  - WEn while WrAllow=0 is ignored; no counter changes.
- Read path, on REn && RdAllow:
  - RCount <= RCount+1.
  - offset < WindowSize-1: offset+1.
  - offset == WindowSize-1 and Pass < EntryReadTimes-1: offset <= 0, Pass+1.
  - offset == WindowSize-1 and Pass == EntryReadTimes-1: offset <= 0, Pass <= 0, base <= base+WindowSize, wrapping to 0 at AddressCount.
- RAddr = base + offset, registered; updates the cycle after the handshake.
- Simultaneous WEn and REn in one cycle: both paths update independently.
- RUN -> DONE when WCount==TotalWriteTimes and RCount==TotalReadTimes, including the edge where the last handshake lands.
- DONE:
  - lasts one cycle; done=1, busy=0, WrAllow=RdAllow=0.
  - always -> IDLE.
  - Counters hold their final values until the next start.
- start outside IDLE is ignored.
- The sequencer does not check entry validity. Read/write ordering safety is provided by the address controller's DataInRdy/DataOutValid; this block only chooses addresses.

Optional Feature:
- Macro: SEQ_STALL_CNT_EN.
- Defined:
  - Adds output StallCount, width TotalReadTimesWidth+4, saturating.
  - Counts RUN cycles where RdAllow=1 and REn=0.
  - Cleared on rst and on start accept; holds in IDLE/DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset check: rst held 3 cycles mid-RUN, then released -> all outputs 0, state IDLE, no done pulse.
- Full tile, no stalls: start, then WEn every cycle and REn every cycle once RdAllow is high.
  - RAddr sequence is 0..8 x5, 9..17 x5, 18..26 x5.
  - WAddr runs 0..26.
  - WrAllow drops after 27 writes.
  - done pulses exactly once, the cycle after the 135th read; WCount=27, RCount=135.
- Backpressure: REn asserted every third cycle -> RAddr holds between handshakes; same address sequence as the full-tile test; done after 135 reads.
- Wrap: AddressCount=18, WindowSize=9, TotalWriteTimes=36, TotalReadTimes=180 -> WAddr wraps 17->0; base wraps 9->0 after the second window; done after 180 reads.
- Spurious inputs:
  - start pulsed during RUN -> ignored; counters unaffected.
  - WEn asserted after 27 writes -> WCount stays 27, WAddr unchanged.
- SEQ_STALL_CNT_EN defined, REn low for 10 RdAllow cycles in total -> StallCount=10 at done; cleared to 0 on the next start.
